seq_detector_param: RTL

- Parametrised Mealy serial-pattern detector; successor to the fixed 3-bit "101" detector.
- Pattern width, reset pattern, overlap mode and counter width are set by parameters; the pattern is also reloadable at runtime.
- Adds an input-valid qualifier, a saturating match counter with clear, and a prefix-progress output.
- Sits on a 1-bit serial input stream inside the FSM exercise block family.

---
 rtl/seq_det_pkg.sv | 64 ++++++
 rtl/seq_det_next.sv | 71 +++++++
 rtl/seq_detector_param.sv | 95 +++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_det_pkg
//  Description : Shared definitions for the parametrised serial-pattern
//                detector. Holds the state-width helper, the pattern-bit
//                accessor and failure_len(), which returns the longest
//                proper prefix of a pattern that is also its suffix.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

  // Widest pattern the detector supports; helpers operate on this width.
  localparam int MAX_PAT_W = 16;

  // State width for the widest build, $clog2(MAX_PAT_W).
  localparam int STATE_W_MAX = $clog2(MAX_PAT_W);

  typedef logic [MAX_PAT_W-1:0] pat_t;

  // State register width for a given pattern length, $clog2(pat_w).
  function automatic int state_width(input int pat_w);
    return (pat_w <= 2) ? 1 : $clog2(pat_w);
  endfunction

  // Single bit of a vector. A shift is used instead of a variable bit-select
  // so that out-of-range indices read as 0 rather than X.
  function automatic logic bit_at(input pat_t v, input int idx);
    pat_t sh;
    sh = v >> idx;
    return sh[0];
  endfunction

  // p[i] of a len-bit pattern held in pattern[len-1:0]; p[0] is the MSB,
  // i.e. the first bit received.
  function automatic logic p_bit(input pat_t pattern, input int len, input int i);
    return bit_at(pattern, len - 1 - i);
  endfunction

  // Longest proper prefix of p[0..len-1] that is also a suffix of it.
  function automatic int failure_len(input pat_t pattern, input int len);
    int   best;
    logic ok;
    best = 0;
    for (int b = 1; b < MAX_PAT_W; b++) begin
      if (b < len) begin
        ok = 1'b1;
        for (int j = 0; j < MAX_PAT_W; j++) begin
          if (j < b) begin
            if (p_bit(pattern, len, j) != p_bit(pattern, len, len - b + j)) begin
              ok = 1'b0;
            end
          end
        end
        if (ok) begin
          best = b;
        end
      end
    end
    return best;
  endfunction

endpackage : seq_det_pkg
`default_nettype wire

// File: rtl/seq_det_next.sv
`default_nettype none
// ============================================================================
//  Module      : seq_det_next
//  Description : Purely combinational KMP transition for the pattern
//                detector. Given the current matched-prefix length and the
//                incoming bit, produces the next prefix length and a full-
//                match flag. Derived directly from the live pattern value, so
//                a reloaded pattern needs no table rebuild.
//  Ports       : i_s       - current matched-prefix length (0..PAT_W-1)
//                i_x       - incoming serial bit
//                i_pattern - pattern, MSB is the first bit expected
//                o_next_s  - prefix length after consuming i_x
//                o_hit     - i_x completes the pattern
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_det_next
  import seq_det_pkg::*;
#(
  parameter int PAT_W   = 3,
  parameter bit OVERLAP = 1'b1,
  localparam int SW     = state_width(PAT_W)
) (
  input  logic [SW-1:0]    i_s,
  input  logic             i_x,
  input  logic [PAT_W-1:0] i_pattern,
  output logic [SW-1:0]    o_next_s,
  output logic             o_hit
);

  pat_t          w_pat;
  logic [SW-1:0] w_fail;
  logic          w_ok;

  assign w_pat  = MAX_PAT_W'(i_pattern);
  assign w_fail = SW'(failure_len(w_pat, PAT_W));

  // For the current state sv, candidate length k is reachable when the last
  // bit matches (p[k-1] == x) and p[0..k-2] is a suffix of p[0..sv-1]. Ascending
  // k means the final accepted candidate is the longest one.
  always_comb begin
    o_hit    = 1'b0;
    o_next_s = '0;
    w_ok     = 1'b0;
    for (int sv = 0; sv < PAT_W; sv++) begin
      if (int'(i_s) == sv) begin
        if ((sv == PAT_W - 1) && (i_x == p_bit(w_pat, PAT_W, PAT_W - 1))) begin
          o_hit    = 1'b1;
          o_next_s = OVERLAP ? w_fail : '0;
        end else begin
          for (int k = 1; k < PAT_W; k++) begin
            if (k <= sv + 1) begin
              w_ok = (p_bit(w_pat, PAT_W, k - 1) == i_x);
              for (int j = 0; j < PAT_W; j++) begin
                if (j < k - 1) begin
                  if (p_bit(w_pat, PAT_W, j) != p_bit(w_pat, PAT_W, sv - k + 1 + j)) begin
                    w_ok = 1'b0;
                  end
                end
              end
              if (w_ok) begin
                o_next_s = SW'(k);
              end
            end
          end
        end
      end
    end
  end

endmodule : seq_det_next
`default_nettype wire

// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detector_param
//  Description : Parametrised Mealy serial-pattern detector with runtime
//                pattern reload, input-valid qualifier, saturating match
//                counter and matched-prefix progress output.
//  Ports       : clk        - clock, rising edge
//                aresetn    - asynchronous active-low reset
//                x          - serial data bit
//                x_valid    - x is consumed only when high
//                pat_we     - load pat_wdata as the pattern (beats x_valid)
//                pat_wdata  - new pattern, MSB first
//                cnt_clr    - synchronous clear of match_cnt
//                z          - Mealy match flag (same cycle as the last bit)
//                prefix_len - current matched-prefix length
//                match_cnt  - saturating match count
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = 3,
  parameter logic [PAT_W-1:0] PATTERN = 3'b101,
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = 8,
  localparam int              SW      = state_width(PAT_W)
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             x,
  input  logic             x_valid,
  input  logic             pat_we,
  input  logic [PAT_W-1:0] pat_wdata,
  input  logic             cnt_clr,
  output logic             z,
  output logic [SW-1:0]    prefix_len,
  output logic [CNT_W-1:0] match_cnt
);

  // Empty-prefix state; every other state value is a prefix length.
  localparam logic [SW-1:0] S_EMPTY = '0;

  logic [SW-1:0]    r_state;
  logic [PAT_W-1:0] r_pattern;
  logic [CNT_W-1:0] r_cnt;
  logic [SW-1:0]    w_next_s;
  logic             w_hit;
  logic             w_accept;
  logic             w_match;

  seq_det_next #(
    .PAT_W   (PAT_W),
    .OVERLAP (OVERLAP)
  ) u_next (
    .i_s       (r_state),
    .i_x       (x),
    .i_pattern (r_pattern),
    .o_next_s  (w_next_s),
    .o_hit     (w_hit)
  );

  // A pattern write steals the cycle: the bit on x is not consumed.
  assign w_accept = x_valid & ~pat_we;
  // Gated by aresetn so z stays low for the whole reset, not just after it.
  assign w_match  = aresetn & w_accept & w_hit;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state   <= S_EMPTY;
      r_pattern <= PATTERN;
    end else if (pat_we) begin
      r_pattern <= pat_wdata;
      r_state   <= S_EMPTY;
    end else if (x_valid) begin
      r_state   <= w_next_s;
    end
  end

  // Clear wins over a same-cycle increment; count holds at all-ones.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (w_match && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign z          = w_match;
  assign prefix_len = r_state;
  assign match_cnt  = r_cnt;

endmodule : seq_detector_param
`default_nettype wire
